// File: rtl/trap_controller_nested.sv
// Nested trap/interrupt controller: edge-captured IRQs, fixed-priority nesting,
// EPC/cause stack and one-cycle PC-redirect pulses toward the fetch stage.
module trap_controller_nested #(
  parameter int unsigned       NUM_IRQ  = 3,
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] VEC_BASE = 32'h0000_0100,
  parameter int unsigned       DEPTH_W  = $clog2(NUM_IRQ + 2)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               instr_valid,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               ecall,
  input  logic               uret,
  input  logic               mask_set,
  input  logic               mask_clr,
  input  logic [NUM_IRQ-1:0] mask_data,
  output logic               trap_take,
  output logic               trap_ret,
  output logic [ADDR_W-1:0]  trap_pc,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic [NUM_IRQ-1:0] in_service,
  output logic [NUM_IRQ-1:0] irq_mask,
  output logic [DEPTH_W-1:0] nest_depth,
  output logic               err
);

  localparam int unsigned STACK_N = NUM_IRQ + 1;
  localparam int unsigned CAUSE_W = $clog2(NUM_IRQ + 1);

  typedef enum logic [1:0] {S_RUN, S_TAKE, S_RET} state_e;

  state_e               state_q;
  logic [NUM_IRQ-1:0]   irq_q, pend_q, mask_q, svc_q, ack_q;
  logic [ADDR_W-1:0]    epc_q   [STACK_N];
  logic [CAUSE_W-1:0]   cause_q [STACK_N];
  logic [DEPTH_W-1:0]   depth_q;
  logic [ADDR_W-1:0]    tpc_q;
  logic                 take_q, ret_q, err_q;

  logic [NUM_IRQ-1:0]   rise_c, takeable_c, elig_c, ack_c, svc_clr_c;
  logic [CAUSE_W-1:0]   irq_idx_c, push_cause_c, top_cause_c;
  logic [ADDR_W-1:0]    push_epc_c, top_epc_c, tgt_c;
  logic                 blocked_c, irq_hit_c, full_c, empty_c;
  logic                 do_take_c, do_ret_c, take_irq_c, err_set_c;

  // Event arbitration: uret > ecall > lowest takeable eligible irq
  always_comb begin
    rise_c    = irq_in & ~irq_q;
    blocked_c = 1'b0;
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      blocked_c     = blocked_c | svc_q[i];
      takeable_c[i] = ~blocked_c;
    end
    elig_c    = pend_q & mask_q & takeable_c;
    irq_hit_c = |elig_c;
    irq_idx_c = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (elig_c[i]) irq_idx_c = CAUSE_W'(i);
    end

    top_epc_c   = '0;
    top_cause_c = '0;
    for (int unsigned k = 0; k < STACK_N; k++) begin
      if (depth_q == DEPTH_W'(k + 1)) begin
        top_epc_c   = epc_q[k];
        top_cause_c = cause_q[k];
      end
    end
    full_c  = (depth_q == DEPTH_W'(STACK_N));
    empty_c = (depth_q == '0);

    do_take_c    = 1'b0;
    do_ret_c     = 1'b0;
    take_irq_c   = 1'b0;
    err_set_c    = 1'b0;
    push_epc_c   = pc;
    push_cause_c = irq_idx_c;
    if (state_q == S_RUN && instr_valid) begin
      if (uret) begin
        if (empty_c) err_set_c = 1'b1;
        else         do_ret_c  = 1'b1;
      end else if (ecall) begin
        push_epc_c   = pc + ADDR_W'(4);
        push_cause_c = CAUSE_W'(NUM_IRQ);
        if (full_c) err_set_c = 1'b1;
        else        do_take_c = 1'b1;
      end else if (irq_hit_c) begin
        if (full_c) begin
          err_set_c = 1'b1;
        end else begin
          do_take_c  = 1'b1;
          take_irq_c = 1'b1;
        end
      end
    end

    ack_c     = take_irq_c ? (NUM_IRQ'(1) << irq_idx_c) : '0;
    svc_clr_c = (do_ret_c && (top_cause_c < CAUSE_W'(NUM_IRQ)))
                ? (NUM_IRQ'(1) << top_cause_c) : '0;
    tgt_c     = do_ret_c ? top_epc_c
                         : VEC_BASE + ADDR_W'({push_cause_c, 2'b00});
  end

  // State, stack and registered redirect outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      irq_q   <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      svc_q   <= '0;
      ack_q   <= '0;
      depth_q <= '0;
      tpc_q   <= '0;
      take_q  <= 1'b0;
      ret_q   <= 1'b0;
      err_q   <= 1'b0;
      for (int unsigned k = 0; k < STACK_N; k++) begin
        epc_q[k]   <= '0;
        cause_q[k] <= '0;
      end
    end else begin
      irq_q  <= irq_in;
      mask_q <= (mask_q | (mask_set ? mask_data : '0)) & ~(mask_clr ? mask_data : '0);
      pend_q <= (pend_q | rise_c) & ~ack_c;
      svc_q  <= (svc_q | ack_c) & ~svc_clr_c;
      err_q  <= err_q | err_set_c;
      take_q <= do_take_c;
      ret_q  <= do_ret_c;
      ack_q  <= ack_c;
      tpc_q  <= (do_take_c || do_ret_c) ? tgt_c : '0;

      if (do_take_c) begin
        for (int unsigned k = 0; k < STACK_N; k++) begin
          if (depth_q == DEPTH_W'(k)) begin
            epc_q[k]   <= push_epc_c;
            cause_q[k] <= push_cause_c;
          end
        end
        depth_q <= depth_q + DEPTH_W'(1);
      end else if (do_ret_c) begin
        depth_q <= depth_q - DEPTH_W'(1);
      end

      case (state_q)
        S_RUN: begin
          if (do_take_c)     state_q <= S_TAKE;
          else if (do_ret_c) state_q <= S_RET;
        end
        default: state_q <= S_RUN;
      endcase
    end
  end

  assign trap_take  = take_q;
  assign trap_ret   = ret_q;
  assign trap_pc    = tpc_q;
  assign irq_ack    = ack_q;
  assign in_service = svc_q;
  assign irq_mask   = mask_q;
  assign nest_depth = depth_q;
  assign err        = err_q;

endmodule

// File: tb/tb_trap_controller_nested.sv
// Bench for trap_controller_nested: directed scenarios plus randomized traffic
// compared cycle by cycle against a queue-based reference model.
module tb_trap_controller_nested;

  localparam int unsigned N = 3;

  logic          clk, rst_n;
  logic [N-1:0]  irq_in;
  logic          instr_valid, ecall, uret, mask_set, mask_clr;
  logic [31:0]   pc;
  logic [N-1:0]  mask_data;
  logic          trap_take, trap_ret, err;
  logic [31:0]   trap_pc;
  logic [N-1:0]  irq_ack, in_service, irq_mask;
  logic [2:0]    nest_depth;

  trap_controller_nested dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .instr_valid(instr_valid),
    .pc(pc), .ecall(ecall), .uret(uret), .mask_set(mask_set),
    .mask_clr(mask_clr), .mask_data(mask_data), .trap_take(trap_take),
    .trap_ret(trap_ret), .trap_pc(trap_pc), .irq_ack(irq_ack),
    .in_service(in_service), .irq_mask(irq_mask), .nest_depth(nest_depth),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  bit [N-1:0]  m_mask, m_pend, m_svc, m_prev;
  bit          m_err, m_cool;
  int unsigned q_epc[$];
  int unsigned q_cause[$];
  bit          e_take, e_ret;
  bit [31:0]   e_pc;
  bit [N-1:0]  e_ack;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_mask = '0; m_pend = '0; m_svc = '0; m_prev = '0;
    m_err = 1'b0; m_cool = 1'b0;
    q_epc.delete(); q_cause.delete();
    e_take = 1'b0; e_ret = 1'b0; e_pc = '0; e_ack = '0;
  endtask

  // One clock of the architectural rules, using the inputs about to be sampled
  task automatic model_step();
    bit [N-1:0] rise;
    int lo, pick;
    int unsigned c;
    rise = irq_in & ~m_prev;
    e_take = 1'b0; e_ret = 1'b0; e_pc = '0; e_ack = '0;
    lo = N;
    for (int i = N - 1; i >= 0; i--) if (m_svc[i]) lo = i;
    pick = -1;
    for (int i = N - 1; i >= 0; i--) if (m_pend[i] && m_mask[i] && i < lo) pick = i;
    if (!m_cool && instr_valid) begin
      if (uret) begin
        if (q_epc.size() == 0) m_err = 1'b1;
        else begin
          e_ret = 1'b1;
          e_pc  = q_epc.pop_back();
          c     = q_cause.pop_back();
          if (c < N) m_svc[c] = 1'b0;
        end
      end else if (ecall) begin
        if (q_epc.size() == N + 1) m_err = 1'b1;
        else begin
          q_epc.push_back(pc + 32'd4);
          q_cause.push_back(N);
          e_take = 1'b1;
          e_pc   = 32'h100 + 4 * N;
        end
      end else if (pick >= 0) begin
        if (q_epc.size() == N + 1) m_err = 1'b1;
        else begin
          q_epc.push_back(pc);
          q_cause.push_back(pick);
          e_take      = 1'b1;
          e_pc        = 32'h100 + 4 * pick;
          e_ack[pick] = 1'b1;
          m_svc[pick] = 1'b1;
        end
      end
    end
    m_pend = (m_pend | rise) & ~e_ack;
    if (mask_set) m_mask = m_mask | mask_data;
    if (mask_clr) m_mask = m_mask & ~mask_data;
    m_cool = e_take | e_ret;
    m_prev = irq_in;
  endtask

  task automatic compare_all();
    check("trap_take", trap_take, e_take);
    check("trap_ret", trap_ret, e_ret);
    if (e_take || e_ret) check("trap_pc", trap_pc, e_pc);
    check("irq_ack", irq_ack, e_ack);
    check("in_service", in_service, m_svc);
    check("irq_mask", irq_mask, m_mask);
    check("nest_depth", nest_depth, q_epc.size());
    check("err", err, m_err);
  endtask

  // Called shortly after a rising edge; sees the next edge and samples 1ns later
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    instr_valid = 1'b0; ecall = 1'b0; uret = 1'b0;
    mask_set = 1'b0; mask_clr = 1'b0; mask_data = '0;
  endtask

  task automatic apply_reset();
    irq_in = '0;
    idle();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    #2 rst_n = 1'b1;
  endtask

  task automatic set_mask(input logic [N-1:0] d);
    idle();
    mask_set = 1'b1; mask_data = d;
    step();
    idle();
  endtask

  initial begin
    rst_n = 1'b0; irq_in = '0; pc = '0;
    idle();
    model_reset();
    @(posedge clk); #1;
    compare_all();
    #2 rst_n = 1'b1;

    // uret with an empty stack
    instr_valid = 1'b1; uret = 1'b1;
    step();
    check("uret_empty_err", err, 1);
    check("uret_empty_noret", trap_ret, 0);
    apply_reset();

    // Basic irq then nesting
    set_mask(3'b111);
    irq_in = 3'b010; pc = 32'h40; instr_valid = 1'b1;
    step();
    step();
    check("basic_take", trap_take, 1);
    check("basic_pc", trap_pc, 32'h104);
    check("basic_ack", irq_ack, 3'b010);
    check("basic_svc", in_service, 3'b010);
    check("basic_depth", nest_depth, 1);
    irq_in = 3'b110;
    step();
    step();
    check("irq2_blocked", trap_take, 0);
    irq_in = 3'b111; pc = 32'h108;
    step();
    step();
    check("nest_pc", trap_pc, 32'h100);
    check("nest_depth2", nest_depth, 2);
    instr_valid = 1'b0;
    step();
    instr_valid = 1'b1; uret = 1'b1;
    step();
    check("ret1_pc", trap_pc, 32'h108);
    check("ret1_svc", in_service, 3'b010);
    step();
    step();
    check("ret2_pc", trap_pc, 32'h40);
    check("ret2_svc", in_service, 3'b000);
    uret = 1'b0;
    step();
    step();
    check("irq2_take_pc", trap_pc, 32'h108);
    check("irq2_ack", irq_ack, 3'b100);
    apply_reset();

    // ecall beats a simultaneous irq[0]
    set_mask(3'b001);
    irq_in = 3'b001;
    step();
    ecall = 1'b1; pc = 32'h200; instr_valid = 1'b1;
    step();
    check("ecall_pc", trap_pc, 32'h10C);
    check("ecall_noack", irq_ack, 3'b000);
    ecall = 1'b0; pc = 32'h300;
    step();
    step();
    check("late_irq0_pc", trap_pc, 32'h100);
    check("late_irq0_depth", nest_depth, 2);
    instr_valid = 1'b0;
    step();
    instr_valid = 1'b1; uret = 1'b1;
    step();
    check("ret_irq0_epc", trap_pc, 32'h300);
    step();
    step();
    check("ret_ecall_epc", trap_pc, 32'h204);
    apply_reset();

    // Set and clear in the same cycle: clear wins
    idle();
    mask_set = 1'b1; mask_clr = 1'b1; mask_data = 3'b001;
    step();
    check("race_mask", irq_mask, 3'b000);
    idle();
    irq_in = 3'b001; instr_valid = 1'b1;
    step();
    step();
    check("race_notrap", trap_take, 0);
    mask_set = 1'b1; mask_data = 3'b001;
    step();
    mask_set = 1'b0;
    step();
    check("race_late_take", trap_take, 1);
    apply_reset();

    // Fill the stack, then overflow with a second ecall
    set_mask(3'b111);
    instr_valid = 1'b1;
    irq_in = 3'b100; step(); step();
    irq_in = 3'b110; step(); step();
    irq_in = 3'b111; step(); step();
    ecall = 1'b1; step(); step();
    check("full_depth", nest_depth, 4);
    step(); step();
    check("ovf_err", err, 1);
    check("ovf_notake", trap_take, 0);
    check("ovf_depth", nest_depth, 4);
    apply_reset();

    // Reset during a trap_take pulse
    set_mask(3'b001);
    irq_in = 3'b001; instr_valid = 1'b1;
    step();
    step();
    check("pre_rst_take", trap_take, 1);
    apply_reset();
    check("rst_take", trap_take, 0);
    check("rst_ack", irq_ack, 3'b000);
    check("rst_depth", nest_depth, 0);

    // Randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 500 == 499) apply_reset();
      for (int b = 0; b < N; b++) if ($urandom_range(0, 5) == 0) irq_in[b] = ~irq_in[b];
      instr_valid = ($urandom_range(0, 9) < 7);
      ecall       = ($urandom_range(0, 19) == 0);
      uret        = ($urandom_range(0, 11) == 0);
      mask_set    = ($urandom_range(0, 15) == 0);
      mask_clr    = ($urandom_range(0, 19) == 0);
      mask_data   = N'($urandom);
      pc          = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/trap_controller_nested.md
# trap_controller_nested

- Sequential trap/interrupt controller that sits beside the instruction decoder.
- Accepts the decoded `ecall`/`uret` strobes plus NUM_IRQ external interrupt lines, and arbitrates by fixed priority with nesting.
- Keeps an EPC/cause stack and issues one-cycle PC-redirect pulses to the fetch stage.
- Interrupt enables are programmed through set/clear strobes driven by the CSRRSI/CSRRCI decode path.

## Interface

Parameters:
- NUM_IRQ, 3, number of interrupt channels; channel 0 has highest priority
- ADDR_W, 32, PC width
- VEC_BASE, 32'h0000_0100, trap vector base; vector = VEC_BASE + 4*cause
- DEPTH_W, $clog2(NUM_IRQ+2), width of the nest-depth counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- irq_in  in  NUM_IRQ  interrupt lines; a rising edge sets the pending bit
- instr_valid  in  1  an instruction at `pc` is retiring this cycle
- pc  in  ADDR_W  address of the current instruction
- ecall  in  1  decoded ecall; qualified by instr_valid
- uret  in  1  decoded uret; qualified by instr_valid
- mask_set  in  1  OR mask_data into the enable mask
- mask_clr  in  1  clear the mask_data bits from the enable mask
- mask_data  in  NUM_IRQ  CSR immediate bits
- trap_take  out  1  one-cycle redirect pulse into the handler
- trap_ret  out  1  one-cycle redirect pulse back to the saved EPC
- trap_pc  out  ADDR_W  redirect target; valid while trap_take or trap_ret is high
- irq_ack  out  NUM_IRQ  one-hot pulse on the channel being entered
- in_service  out  NUM_IRQ  channels currently being serviced
- irq_mask  out  NUM_IRQ  current enable mask
- nest_depth  out  DEPTH_W  number of stack entries
- err  out  1  sticky: stack overflow or uret with an empty stack

## Operation

- **Reset values.** All outputs are 0: mask, pending, stack, in_service, depth, err. The FSM is in RUN.
- **Edge detect.** irq_in is registered each cycle. A rising edge sets pending[i]. Further edges on a bit that is already pending are not counted.
- **Mask update.** mask_set and mask_clr take effect next cycle. If both are asserted in the same cycle, clear wins on the overlapping bits.
- **Eligible channels.** eligible = pending & irq_mask. A channel is takeable only if its index is lower than the lowest-indexed in_service bit. Any channel is takeable when in_service = 0.
- **Event priority**, evaluated in RUN only when instr_valid = 1, one event per cycle, first match wins:
  1. uret
  2. ecall
  3. lowest-index takeable eligible irq
- **ecall.**
  - Push {EPC = pc+4, cause = NUM_IRQ}.
  - Target = VEC_BASE + 4*NUM_IRQ.
- **irq i.**
  - Push {EPC = pc, cause = i}; the instruction at `pc` is squashed.
  - Clear pending[i], set in_service[i], pulse irq_ack[i].
  - Target = VEC_BASE + 4*i.
- **uret.**
  - Pop the stack. Target = popped EPC.
  - If the popped cause < NUM_IRQ, clear in_service[cause].
- **Stack.** Depth is NUM_IRQ+1, so every channel plus one ecall can nest.
  - Push while full: set err, no push, no redirect; the instruction retires normally.
  - uret while empty: set err, no redirect.
- **FSM.**
  - RUN → TAKE when an ecall or irq is accepted.
  - RUN → RET when a uret is accepted.
  - TAKE → RUN and RET → RUN unconditionally after one cycle.
  - In TAKE and RET, ecall, uret and irq acceptance are ignored. Edge capture and mask updates continue.
- **Width rules.** EPC and vector arithmetic are modulo 2^ADDR_W. nest_depth saturates at NUM_IRQ+1 and never underflows.

## Timing

- Event sampled at edge t. At t+1 the stack, pending, in_service and nest_depth are updated, and trap_take or trap_ret, trap_pc and irq_ack are high for exactly one cycle.
- Minimum spacing between redirects is 2 cycles.
- An irq edge at edge t sets pending at t+1. The earliest trap_take is then t+2, provided instr_valid and the mask allow it.
- rst_n low at any time, including while a pulse is high: all state clears immediately. trap_take, trap_ret and irq_ack drop without waiting for a clock.

## Test plan

- **Reset and basic irq.** Assert rst_n low, then release. mask_set with data 3'b111. Edge on irq_in[1] with pc=0x40 and instr_valid=1. Expect: trap_take pulse with trap_pc=0x104, irq_ack=3'b010, in_service=3'b010, nest_depth=1.
- **Nesting.** While channel 1 is in service:
  - Edge on irq[2]: stays pending.
  - Edge on irq[0] with pc=0x108: taken, trap_pc=0x100, depth=2.
  - uret: trap_ret to 0x108, in_service=010.
  - Next uret: return to 0x40. irq[2] is then taken at the following instr_valid.
- **Simultaneous ecall and irq.** ecall at pc=0x200 in the same cycle as an enabled irq[0]. Expect: ecall wins, trap_pc=0x10C, EPC 0x204 pushed. irq[0] is taken 2 cycles later with EPC=pc at that time.
- **Mask races.** mask_set and mask_clr in the same cycle, both with data 3'b001, followed by an irq[0] edge. Expect: mask bit 0 = 0, pending[0]=1, no trap. A later mask_set of bit 0 causes the trap to be taken.
- **Errors.**
  - uret at reset: err=1, no trap_ret.
  - Fill the stack (3 irqs + ecall), then a second ecall: err=1, no trap_take, nest_depth=4.
- **Reset mid-pulse.** Drive rst_n low during a trap_take cycle. Expect: trap_take=0 immediately, and all state cleared.
